// File: rtl/cordic_vec_iter.sv
// Iterative CORDIC vectoring unit: one micro-rotation per cycle, returns |v| and atan2(y, x).
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain from mag_out.
module cordic_vec_iter #(
  parameter int WIDTH   = 16,
  parameter int ITER    = 14,
  parameter int ANGLE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH:0]            mag_out,
  output logic signed [ANGLE_W-1:0] phase_out
);

  // x/y keep WIDTH+2 integer bits of headroom plus Frac fraction bits, so bits shifted out
  // by the micro-rotations do not bias the residual angle.
  localparam int  Frac = 8;
  localparam int  Xw   = WIDTH + 2 + Frac;
  localparam int  CntW = $clog2(ITER);
  localparam real Pi   = 3.14159265358979323846;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StRot   = 3'd2;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [2:0] StScale = 3'd3;
`endif
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [ANGLE_W-1:0] QuarterPos = {2'b01, {(ANGLE_W-2){1'b0}}};
  localparam logic [ANGLE_W-1:0] QuarterNeg = {2'b11, {(ANGLE_W-2){1'b0}}};

  function automatic real atan_rad(input int i);
    case (i)
      0:       return 0.7853981633974483;
      1:       return 0.4636476090008061;
      2:       return 0.24497866312686414;
      3:       return 0.12435499454676144;
      4:       return 0.06241880999595735;
      5:       return 0.031239833430268277;
      6:       return 0.015623728620476831;
      7:       return 0.007812341060101111;
      8:       return 0.0039062301319669718;
      9:       return 0.0019531225164788188;
      10:      return 0.0009765621895593195;
      11:      return 0.0004882812111948983;
      12:      return 0.00024414062014936177;
      13:      return 0.00012207031189367021;
      14:      return 0.00006103515617420877;
      15:      return 0.000030517578115526096;
      default: return 2.0 ** (-i);  // atan(x) == x to well below one phase LSB here
    endcase
  endfunction

  function automatic logic [ANGLE_W-1:0] atan_code(input int i);
    return ANGLE_W'(longint'(atan_rad(i) * (2.0 ** (ANGLE_W - 1)) / Pi));
  endfunction

  logic [ANGLE_W-1:0] atan_rom [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic [ANGLE_W-1:0] Code = atan_code(g);
    assign atan_rom[g] = Code;
  end

  logic [2:0]               state_q, state_d;
  logic signed [Xw-1:0]     x_q, x_d, y_q, y_d;
  logic signed [Xw-1:0]     x_sh, y_sh;
  logic [ANGLE_W-1:0]       z_q, z_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     zero_q, zero_d;
  logic [WIDTH:0]           mag_q, mag_d;
  logic [ANGLE_W-1:0]       phase_q, phase_d;

`ifdef CORDIC_GAIN_COMP_EN
  localparam longint           GainL = longint'((2.0 ** WIDTH) / 1.646760);
  localparam logic [WIDTH-1:0] Gain  = GainL[WIDTH-1:0];
  logic signed [Xw+WIDTH:0] prod;
  assign prod = x_q * $signed({1'b0, Gain});
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = {{2{x_in[WIDTH-1]}}, x_in, {Frac{1'b0}}};
          y_d     = {{2{y_in[WIDTH-1]}}, y_in, {Frac{1'b0}}};
          z_d     = '0;
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = StPre;
        end
      end
      StPre: begin
        // Fold the left half-plane onto the right so the rotations converge.
        if (x_q[Xw-1]) begin
          if (!y_q[Xw-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = QuarterPos;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = QuarterNeg;
          end
        end
        state_d = StRot;
      end
      StRot: begin
        if (!y_q[Xw-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_rom[cnt_q];
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_rom[cnt_q];
        end
        if (cnt_q == CntW'(ITER - 1)) begin
          // A zero vector has no defined angle; report 0 instead of the sum of the table.
          phase_d = zero_q ? '0 : z_d;
`ifdef CORDIC_GAIN_COMP_EN
          state_d = StScale;
`else
          mag_d   = x_d[Frac +: WIDTH+1];
          state_d = StDone;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      StScale: begin
        mag_d   = (WIDTH+1)'(prod >>> (WIDTH + Frac));
        state_d = StDone;
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign mag_out   = mag_q;
  assign phase_out = phase_q;

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Directed bench for cordic_vec_iter at default parameters: vector table, output stall and
// mid-computation reset. Expectations follow CORDIC_GAIN_COMP_EN when defined.
module tb_cordic_vec_iter;

  localparam int WIDTH   = 16;
  localparam int ITER    = 14;
  localparam int ANGLE_W = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT   = ITER + 3;
  localparam int M1000 = 1000;
  localparam int M1414 = 1414;
  localparam int MBIG  = 46341;
`else
  localparam int LAT   = ITER + 2;
  localparam int M1000 = 1647;
  localparam int M1414 = 2329;
  localparam int MBIG  = 76312;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      out_ready = 1'b0;
  logic signed [WIDTH-1:0]   x_in = '0;
  logic signed [WIDTH-1:0]   y_in = '0;
  logic                      in_ready;
  logic                      out_valid;
  logic [WIDTH:0]            mag_out;
  logic signed [ANGLE_W-1:0] phase_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_vec_iter #(
    .WIDTH  (WIDTH),
    .ITER   (ITER),
    .ANGLE_W(ANGLE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_out  (mag_out),
    .phase_out(phase_out)
  );

  typedef struct {
    int x;
    int y;
    int mag;
    int mag_tol;
    int phase;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Phase wraps modulo 2^ANGLE_W, so compare the wrapped difference.
  task automatic check_phase(input string name, input logic signed [ANGLE_W-1:0] act,
                             input int exp);
    logic signed [ANGLE_W-1:0] d;
    d = act - ANGLE_W'(exp);
    checks++;
    if (d > 2 || d < -2) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (tol 2, modulo 2^%0d)", name, act, exp, ANGLE_W);
    end
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    check("in_ready before send", in_ready, 1, 0);
    x_in     = WIDTH'(x);
    y_in     = WIDTH'(y);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts clock edges from the transfer edge (inclusive) to the edge after which
  // out_valid is seen; bounded so a dead DUT still reaches the summary.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("out_valid after release", out_valid, 0, 0);
    check("in_ready after release", in_ready, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    int   bad;

    vecs[0] = '{1000, 0, M1000, 2, 0};
    vecs[1] = '{0, 1000, M1000, 2, 16384};
    vecs[2] = '{1000, 1000, M1414, 2, 8192};
    vecs[3] = '{-1000, 0, M1000, 2, -32768};
    vecs[4] = '{-1000, -1000, M1414, 2, -24576};
    vecs[5] = '{0, -1000, M1000, 2, -16384};
    vecs[6] = '{0, 0, 0, 0, 0};
    vecs[7] = '{-32768, -32768, MBIG, 3, -24576};

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset out_valid", out_valid, 0, 0);
    check("reset mag_out", mag_out, 0, 0);
    check("reset phase_out", phase_out, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready after reset", in_ready, 1, 0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].x, vecs[i].y);
      wait_out(lat);
      check($sformatf("latency v%0d", i), lat, LAT, 0);
      check($sformatf("mag v%0d", i), mag_out, vecs[i].mag, vecs[i].mag_tol);
      check_phase($sformatf("phase v%0d", i), phase_out, vecs[i].phase);
      release_out();
    end

    // Stall the output for 10 cycles; a second in_valid pulse must be dropped.
    send(1000, 1000);
    wait_out(lat);
    check("stall latency", lat, LAT, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      x_in     = 16'sd5;
      y_in     = 16'sd5;
      check($sformatf("stall out_valid c%0d", c), out_valid, 1, 0);
      check($sformatf("stall in_ready c%0d", c), in_ready, 0, 0);
      check($sformatf("stall mag c%0d", c), mag_out, M1414, 2);
      check_phase($sformatf("stall phase c%0d", c), phase_out, 8192);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stall mag held", mag_out, M1414, 2);
    release_out();
    bad = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("ignored pulse not queued", bad, 0, 0);

    // Reset during iteration 5 aborts the vector.
    send(1000, 0);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0, 0);
    check("abort mag_out", mag_out, 0, 0);
    check("abort phase_out", phase_out, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready || mag_out != '0 || phase_out != '0) bad++;
    end
    check("aborted vector emits nothing", bad, 0, 0);

    send(-32768, -32768);
    wait_out(lat);
    check("post-reset latency", lat, LAT, 0);
    check("post-reset mag", mag_out, MBIG, 3);
    check_phase("post-reset phase", phase_out, -24576);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_vec_iter.md
CORDIC_VEC_ITER -- requirements
Module: cordic_vec_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the signed input sample width in bits (range 8..24).
REQ-002 The block SHALL have parameter ITER, default 14, giving the number of CORDIC micro-rotations (range 4..WIDTH).
REQ-003 The block SHALL have parameter ANGLE_W, default 16, giving the phase width in bits, where 2^(ANGLE_W-1) represents pi.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  asynchronous active-high reset.
REQ-007 Port: in_valid  in  1  input vector valid.
REQ-008 Port: in_ready  out  1  block can accept a vector.
REQ-009 Port: x_in  in  WIDTH  signed X component.
REQ-010 Port: y_in  in  WIDTH  signed Y component.
REQ-011 Port: out_valid  out  1  result valid.
REQ-012 Port: out_ready  in  1  downstream accepts result.
REQ-013 Port: mag_out  out  WIDTH+1  unsigned magnitude.
REQ-014 Port: phase_out  out  ANGLE_W  signed phase, atan2(y,x).

Function
REQ-015 The FSM SHALL have the states IDLE, PRE, ROT, SCALE and DONE; SCALE exists only when the configuration macro is defined.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge, capturing x_in and y_in and moving the FSM to PRE.
REQ-017 PRE (1 cycle) SHALL pre-rotate vectors with x<0: if y>=0, (x,y)->(y,-x) and z=+2^(ANGLE_W-2); if y<0, (x,y)->(-y,x) and z=-2^(ANGLE_W-2); otherwise z=0.
REQ-018 ROT SHALL perform exactly one micro-rotation per cycle for i=0..ITER-1.
  - d = +1 if y>=0, else -1.
  - x' = x + d*(y>>>i); y' = y - d*(x>>>i); z' = z + d*atan(2^-i).
  - Arithmetic shifts.
REQ-019 Internal x/y registers SHALL be WIDTH+2 bits signed so that no overflow occurs for any input, including (-2^(WIDTH-1), -2^(WIDTH-1)).
REQ-020 The atan table SHALL be a constant per-entry ROM of round(atan(2^-i)*2^(ANGLE_W-1)/pi), for i=0..ITER-1.
REQ-021 z SHALL wrap modulo 2^ANGLE_W; an input of (-A,0) SHALL yield phase_out = -2^(ANGLE_W-1).
REQ-022 After the last micro-rotation, the FSM SHALL go to DONE (or SCALE); mag_out SHALL be the final x, truncated to WIDTH+1 bits, and phase_out SHALL be the final z.
REQ-023 Total latency from input transfer to out_valid=1 SHALL be ITER+2 cycles without the macro and ITER+3 cycles with it.
REQ-024 In DONE, out_valid SHALL be 1 and mag_out/phase_out SHALL hold stable until out_ready=1.
  - Then the FSM returns to IDLE next cycle.
  - No new input is accepted in the same cycle.
REQ-025 in_valid asserted while busy SHALL be ignored (not captured, not queued).
REQ-026 The input (0,0) SHALL produce mag_out=0 and phase_out=0.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, in_ready=1 (after deassertion, in IDLE), out_valid=0, mag_out=0, phase_out=0, and clear all internal x/y/z/iteration registers.
REQ-028 rst asserted mid-computation SHALL abort the operation with no result emitted; the first transfer after rst deassertion SHALL be processed normally.

Configuration
REQ-029 Macro CORDIC_GAIN_COMP_EN SHALL control gain compensation.
  - Defined: SCALE (1 cycle) multiplies final x by round(2^(WIDTH)/1.646760) and shifts right by WIDTH, so mag_out ≈ |v| within ±2 LSB.
  - Undefined: mag_out = K*|v|, with K ≈ 1.64676, and no SCALE state exists.
  - phase_out SHALL be identical in both builds.

Verification
REQ-030 Input x=1000, y=0 (defaults) -> phase_out=0±2; mag_out=1647±2 without the macro, 1000±2 with it; out_valid exactly at ITER+2 / ITER+3 cycles.
REQ-031 Input x=0, y=1000 -> phase_out=16384±2; x=1000, y=1000 -> phase_out=8192±2, with the macro mag_out=1414±2.
REQ-032 Input x=-1000, y=0 -> phase_out=-32768±2; x=-1000, y=-1000 -> phase_out=-24576±2.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid pulse is ignored; release -> out_valid=0 and in_ready=1 next cycle.
REQ-034 Assert rst at iteration 5 -> out_valid never rises for that vector, all outputs read 0; a new vector (x=-32768, y=-32768) -> phase_out=-24576±2, no overflow, with the macro mag_out=46341±3.
